control_unit: RTL and testbench

Hardwired Mini SRC control sequencer that drives every strobe the datapath expects: register in/out enables, select-and-encode controls, memory Read/Write, ALU opcode and CON FF load. It runs the three-state fetch, then decodes IR_Data and steps through the execute states for the instruction. It sits directly upstream of the datapath, in place of the hand-sequenced strobes a bench drives today, and samples CON_out back from the datapath for conditional branches.

---
 rtl/minisrc_pkg.sv | 54 +++++
 rtl/control_decode.sv | 97 +++++++++
 rtl/control_unit.sv | 98 +++++++++
 tb/tb_control_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared Mini SRC constants: opcodes, ALU codes, C2 branch conditions, sequencer states and the
// strobe bundle driven towards the datapath.
package minisrc_pkg;

  localparam logic [4:0] OpLd   = 5'b00000, OpLdi  = 5'b00001, OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011, OpSub  = 5'b00100, OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110, OpRor  = 5'b00111, OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001, OpShra = 5'b01010, OpShl  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100, OpAndi = 5'b01101, OpOri  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111, OpMul  = 5'b10000, OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010, OpBr   = 5'b10011, OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101, OpIn   = 5'b10110, OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000, OpMflo = 5'b11001, OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // The ALU reuses the opcode encoding; address and branch-target arithmetic use AluAdd.
  localparam logic [4:0] AluAdd = OpAdd, AluSub = OpSub, AluMul = OpMul, AluDiv = OpDiv;

  localparam logic [1:0] CondZero = 2'b00, CondNonzero = 2'b01, CondPlus = 2'b10;
  localparam logic [1:0] CondMinus = 2'b11;

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef struct packed {
    logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc;
    logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic gra, grb, grc, rin, rout, ba_out, con_in, read, write, rx15;
    logic [4:0] alu;
  } ctrl_t;

  function automatic logic is_reg_alu(logic [4:0] op);
    return (op >= OpAdd) && (op <= OpShl);
  endfunction

  function automatic logic is_imm_alu(logic [4:0] op);
    return (op >= OpAddi) && (op <= OpOri);
  endfunction

  function automatic logic is_mem(logic [4:0] op);
    return (op == OpLd) || (op == OpLdi) || (op == OpSt);
  endfunction

  // Final execute state of each instruction; unknown opcodes behave as nop.
  function automatic state_e exec_last(logic [4:0] op);
    if (op == OpLd || op == OpSt) return StT7;
    if (is_reg_alu(op) || is_imm_alu(op) || op == OpLdi) return StT5;
    if (op == OpMul || op == OpDiv || op == OpBr) return StT6;
    if (op == OpNeg || op == OpNot || op == OpJal) return StT4;
    return StT3;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe map from sequencer state and opcode to the datapath control bundle.
module control_decode
  import minisrc_pkg::*;
(
  input  state_e      state,
  input  logic [4:0]  op,
  input  logic        con_taken,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StT0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
      end
      StT1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      StT2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      StT3: begin
        if (is_reg_alu(op) || is_imm_alu(op)) begin
          ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
        end else if (is_mem(op)) begin
          ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
        end else if (op == OpMul || op == OpDiv) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
        end else if (op == OpNeg || op == OpNot) begin
          ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op;
        end else if (op == OpBr) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1;
        end else if (op == OpJr) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1;
        end else if (op == OpJal) begin
          ctrl.pc_out = 1'b1; ctrl.rx15 = 1'b1;
        end else if (op == OpIn) begin
          ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (op == OpOut) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outport_in = 1'b1;
        end else if (op == OpMfhi || op == OpMflo) begin
          ctrl.hi_out = (op == OpMfhi); ctrl.lo_out = (op == OpMflo);
          ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end
      end
      StT4: begin
        if (is_reg_alu(op)) begin
          ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op;
        end else if (is_imm_alu(op)) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op;
        end else if (is_mem(op)) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = AluAdd;
        end else if (op == OpMul || op == OpDiv) begin
          ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op;
        end else if (op == OpNeg || op == OpNot) begin
          ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (op == OpBr) begin
          ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
        end else if (op == OpJal) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1;
        end
      end
      StT5: begin
        if (is_reg_alu(op) || is_imm_alu(op) || op == OpLdi) begin
          ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (op == OpLd || op == OpSt) begin
          ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
        end else if (op == OpMul || op == OpDiv) begin
          ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
        end else if (op == OpBr) begin
          ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = AluAdd;
        end
      end
      StT6: begin
        if (op == OpLd) begin
          ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        end else if (op == OpSt) begin
          ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1;
        end else if (op == OpMul || op == OpDiv) begin
          ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
        end else if (op == OpBr && con_taken) begin
          ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1;
        end
      end
      StT7: begin
        if (op == OpLd) begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
        end else if (op == OpSt) begin
          ctrl.write = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: three-state fetch, opcode decode, then per-instruction execute
// states. Strobes are a Moore decode of the state register and the latched opcode.
module control_unit
  import minisrc_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  input  logic        Stop,
  output logic        Run,
  output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
  output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        CON_in,
  output logic        Read, Write,
  output logic [4:0]  alu_instruction_bits,
  output logic [15:0] RX_in_man
);

  state_e     state_q;
  logic [4:0] opcode_q;
  logic       con_q;
  logic [4:0] op_cur;
  ctrl_t      ctrl;
  logic       unused_ir;

  assign unused_ir = ^IR_Data[26:0];

  // IR is only loaded at the end of T2, so T3 decodes the live IR field; later states use the latch.
  assign op_cur = (state_q == StT3) ? IR_Data[31:27] : opcode_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StReset;
      opcode_q <= '0;
      con_q    <= 1'b0;
    end else begin
      if (state_q == StT2 || state_q == StT3) opcode_q <= IR_Data[31:27];
      // CON FF settled since T3; capture it entering T6 so the branch strobes stay Moore.
      if (state_q == StT5) con_q <= CON_out;
      case (state_q)
        StReset: state_q <= StT0;
        StT0:    state_q <= StT1;
        StT1:    state_q <= StT2;
        StT2:    state_q <= StT3;
        StHalt:  state_q <= StHalt;
        default: begin
          if (state_q == exec_last(op_cur)) begin
            state_q <= (Stop || op_cur == OpHalt) ? StHalt : StT0;
          end else begin
            state_q <= state_e'(state_q + 4'd1);
          end
        end
      endcase
    end
  end

  control_decode u_decode (
    .state     (state_q),
    .op        (op_cur),
    .con_taken (con_q),
    .ctrl      (ctrl)
  );

  assign Run = (state_q != StReset) && (state_q != StHalt);

  assign PC_in      = ctrl.pc_in;
  assign IR_in      = ctrl.ir_in;
  assign Y_in       = ctrl.y_in;
  assign Z_in       = ctrl.z_in;
  assign HI_in      = ctrl.hi_in;
  assign LO_in      = ctrl.lo_in;
  assign MAR_in     = ctrl.mar_in;
  assign MDR_in     = ctrl.mdr_in;
  assign OutPort_in = ctrl.outport_in;
  assign IncPC      = ctrl.inc_pc;
  assign PC_out     = ctrl.pc_out;
  assign Zhigh_out  = ctrl.zhigh_out;
  assign Zlow_out   = ctrl.zlow_out;
  assign HI_out     = ctrl.hi_out;
  assign LO_out     = ctrl.lo_out;
  assign MDR_out    = ctrl.mdr_out;
  assign InPort_out = ctrl.inport_out;
  assign C_out      = ctrl.c_out;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Rin        = ctrl.rin;
  assign Rout       = ctrl.rout;
  assign BAout      = ctrl.ba_out;
  assign CON_in     = ctrl.con_in;
  assign Read       = ctrl.read;
  assign Write      = ctrl.write;
  assign alu_instruction_bits = ctrl.alu;
  assign RX_in_man  = {ctrl.rx15, 15'b0};

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of per-state strobe expectations plus hand-written
// sequences for async reset, Stop/HALT and back-to-back ld/st.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] IR_Data = '0;
  logic        CON_out = 1'b0;
  logic        Stop = 1'b0;
  logic        Run;
  logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, CON_in, Read, Write;
  logic [4:0]  alu_instruction_bits;
  logic [15:0] RX_in_man;

  int total = 0;
  int bad = 0;
  int viol = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .Stop(Stop), .Run(Run),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
    .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC),
    .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
    .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .CON_in(CON_in), .Read(Read), .Write(Write),
    .alu_instruction_bits(alu_instruction_bits), .RX_in_man(RX_in_man)
  );

  localparam logic [32:0] S_PC_IN  = 33'd1 << 32, S_IR_IN  = 33'd1 << 31, S_Y_IN   = 33'd1 << 30;
  localparam logic [32:0] S_Z_IN   = 33'd1 << 29, S_HI_IN  = 33'd1 << 28, S_LO_IN  = 33'd1 << 27;
  localparam logic [32:0] S_MAR_IN = 33'd1 << 26, S_MDR_IN = 33'd1 << 25, S_OUTP   = 33'd1 << 24;
  localparam logic [32:0] S_INCPC  = 33'd1 << 23, S_PC_OUT = 33'd1 << 22, S_ZHI    = 33'd1 << 21;
  localparam logic [32:0] S_ZLO    = 33'd1 << 20, S_HI_OUT = 33'd1 << 19, S_LO_OUT = 33'd1 << 18;
  localparam logic [32:0] S_MDROUT = 33'd1 << 17, S_INP    = 33'd1 << 16, S_C_OUT  = 33'd1 << 15;
  localparam logic [32:0] S_GRA    = 33'd1 << 14, S_GRB    = 33'd1 << 13, S_GRC    = 33'd1 << 12;
  localparam logic [32:0] S_RIN    = 33'd1 << 11, S_ROUT   = 33'd1 << 10, S_BAOUT  = 33'd1 << 9;
  localparam logic [32:0] S_CON_IN = 33'd1 << 8,  S_READ   = 33'd1 << 7,  S_WRITE  = 33'd1 << 6;
  localparam logic [32:0] S_RX15   = 33'd1 << 5;
  localparam logic [32:0] V_T0 = S_PC_OUT | S_MAR_IN | S_INCPC | S_Z_IN;
  localparam logic [32:0] V_T1 = S_ZLO | S_PC_IN | S_READ | S_MDR_IN;
  localparam logic [32:0] V_T2 = S_MDROUT | S_IR_IN;

  function automatic logic [32:0] alu(logic [4:0] a);
    return {28'b0, a};
  endfunction

  function automatic logic [31:0] ir_of(logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
            PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
            Gra, Grb, Grc, Rin, Rout, BAout, CON_in, Read, Write, RX_in_man[15],
            alu_instruction_bits};
  endfunction

  // Read/Write overlap or a stray low RX_in_man bit is illegal in any state.
  always @(negedge clk) begin
    if ((Read && Write) || (RX_in_man[14:0] != 15'd0)) viol++;
  end

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        con;
    int          cyc;
    logic [32:0] exp;
    logic        run;
  } vec_t;

  vec_t tv[$];

  task automatic add(string name, logic [31:0] ir, logic con, int cyc, logic [32:0] exp,
                     logic run);
    vec_t v;
    v.name = name; v.ir = ir; v.con = con; v.cyc = cyc; v.exp = exp; v.run = run;
    tv.push_back(v);
  endtask

  task automatic chk(string name, logic [32:0] exp, logic exp_run);
    total++;
    if (dut_vec() !== exp || Run !== exp_run) begin
      bad++;
      $display("FAIL %s: got strobes=%h run=%b, want strobes=%h run=%b",
               name, dut_vec(), Run, exp, exp_run);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    add("fetch_t0", ir_of(5'b00000), 0, 0, V_T0, 1);
    add("fetch_t1", ir_of(5'b00000), 0, 1, V_T1, 1);
    add("fetch_t2", ir_of(5'b00000), 0, 2, V_T2, 1);
    add("add_t3", ir_of(5'b00011), 0, 3, S_GRB | S_ROUT | S_Y_IN, 1);
    add("add_t4", ir_of(5'b00011), 0, 4, S_GRC | S_ROUT | S_Z_IN | alu(5'b00011), 1);
    add("add_t5", ir_of(5'b00011), 0, 5, S_ZLO | S_GRA | S_RIN, 1);
    add("add_next", ir_of(5'b00011), 0, 6, V_T0, 1);
    add("shra_t4", ir_of(5'b01010), 0, 4, S_GRC | S_ROUT | S_Z_IN | alu(5'b01010), 1);
    add("addi_t3", 32'h611FFFFB, 0, 3, S_GRB | S_ROUT | S_Y_IN, 1);
    add("addi_t4", 32'h611FFFFB, 0, 4, S_C_OUT | S_Z_IN | alu(5'b01100), 1);
    add("addi_t5", 32'h611FFFFB, 0, 5, S_ZLO | S_GRA | S_RIN, 1);
    add("ori_t4", ir_of(5'b01110), 0, 4, S_C_OUT | S_Z_IN | alu(5'b01110), 1);
    add("ld_t3", ir_of(5'b00000), 0, 3, S_GRB | S_BAOUT | S_Y_IN, 1);
    add("ld_t4", ir_of(5'b00000), 0, 4, S_C_OUT | S_Z_IN | alu(5'b00011), 1);
    add("ld_t5", ir_of(5'b00000), 0, 5, S_ZLO | S_MAR_IN, 1);
    add("ld_t6", ir_of(5'b00000), 0, 6, S_READ | S_MDR_IN, 1);
    add("ld_t7", ir_of(5'b00000), 0, 7, S_MDROUT | S_GRA | S_RIN, 1);
    add("ld_next", ir_of(5'b00000), 0, 8, V_T0, 1);
    add("ldi_t5", ir_of(5'b00001), 0, 5, S_ZLO | S_GRA | S_RIN, 1);
    add("ldi_next", ir_of(5'b00001), 0, 6, V_T0, 1);
    add("st_t5", ir_of(5'b00010), 0, 5, S_ZLO | S_MAR_IN, 1);
    add("st_t6", ir_of(5'b00010), 0, 6, S_GRA | S_ROUT | S_MDR_IN, 1);
    add("st_t7", ir_of(5'b00010), 0, 7, S_WRITE, 1);
    add("mul_t3", ir_of(5'b10000), 0, 3, S_GRA | S_ROUT | S_Y_IN, 1);
    add("mul_t4", ir_of(5'b10000), 0, 4, S_GRB | S_ROUT | S_Z_IN | alu(5'b10000), 1);
    add("mul_t5", ir_of(5'b10000), 0, 5, S_ZLO | S_LO_IN, 1);
    add("mul_t6", ir_of(5'b10000), 0, 6, S_ZHI | S_HI_IN, 1);
    add("mul_next", ir_of(5'b10000), 0, 7, V_T0, 1);
    add("div_t4", ir_of(5'b01111), 0, 4, S_GRB | S_ROUT | S_Z_IN | alu(5'b01111), 1);
    add("neg_t3", ir_of(5'b10001), 0, 3, S_GRB | S_ROUT | S_Z_IN | alu(5'b10001), 1);
    add("not_t3", ir_of(5'b10010), 0, 3, S_GRB | S_ROUT | S_Z_IN | alu(5'b10010), 1);
    add("not_t4", ir_of(5'b10010), 0, 4, S_ZLO | S_GRA | S_RIN, 1);
    add("not_next", ir_of(5'b10010), 0, 5, V_T0, 1);
    add("brt_t3", 32'h9B000019, 1, 3, S_GRA | S_ROUT | S_CON_IN, 1);
    add("brt_t4", 32'h9B000019, 1, 4, S_PC_OUT | S_Y_IN, 1);
    add("brt_t5", 32'h9B000019, 1, 5, S_C_OUT | S_Z_IN | alu(5'b00011), 1);
    add("brt_t6", 32'h9B000019, 1, 6, S_ZLO | S_PC_IN, 1);
    add("brt_next", 32'h9B000019, 1, 7, V_T0, 1);
    add("brf_t6", 32'h9B000019, 0, 6, 33'd0, 1);
    add("brf_next", 32'h9B000019, 0, 7, V_T0, 1);
    add("jr_t3", ir_of(5'b10100), 0, 3, S_GRA | S_ROUT | S_PC_IN, 1);
    add("jr_next", ir_of(5'b10100), 0, 4, V_T0, 1);
    add("jal_t3", ir_of(5'b10101), 0, 3, S_PC_OUT | S_RX15, 1);
    add("jal_t4", ir_of(5'b10101), 0, 4, S_GRA | S_ROUT | S_PC_IN, 1);
    add("in_t3", ir_of(5'b10110), 0, 3, S_INP | S_GRA | S_RIN, 1);
    add("out_t3", ir_of(5'b10111), 0, 3, S_GRA | S_ROUT | S_OUTP, 1);
    add("out_next", ir_of(5'b10111), 0, 4, V_T0, 1);
    add("mfhi_t3", ir_of(5'b11000), 0, 3, S_HI_OUT | S_GRA | S_RIN, 1);
    add("mflo_t3", ir_of(5'b11001), 0, 3, S_LO_OUT | S_GRA | S_RIN, 1);
    add("nop_t3", ir_of(5'b11010), 0, 3, 33'd0, 1);
    add("nop_next", ir_of(5'b11010), 0, 4, V_T0, 1);
    add("undef_t3", ir_of(5'b11111), 0, 3, 33'd0, 1);
    add("undef_next", ir_of(5'b11111), 0, 4, V_T0, 1);
    add("halt_t3", ir_of(5'b11011), 0, 3, 33'd0, 1);
    add("halt_after", ir_of(5'b11011), 0, 4, 33'd0, 0);
    add("halt_hold", ir_of(5'b11011), 0, 12, 33'd0, 0);

    do_reset();
    chk("reset_state", 33'd0, 1'b0);

    foreach (tv[i]) begin
      IR_Data = tv[i].ir;
      CON_out = tv[i].con;
      Stop    = 1'b0;
      do_reset();
      repeat (tv[i].cyc + 1) tick();
      chk(tv[i].name, tv[i].exp, tv[i].run);
    end

    // Asynchronous clear in the middle of mul T4, then restart from fetch.
    IR_Data = ir_of(5'b10000);
    do_reset();
    repeat (5) tick();
    chk("mul_t4_pre_clr", S_GRB | S_ROUT | S_Z_IN | alu(5'b10000), 1'b1);
    #2 clr = 1'b0;
    #1 chk("clr_async", 33'd0, 1'b0);
    @(posedge clk);
    #1 chk("clr_held", 33'd0, 1'b0);
    clr = 1'b1;
    tick();
    chk("clr_release_t0", V_T0, 1'b1);

    // Back-to-back ld then st.
    IR_Data = ir_of(5'b00000);
    do_reset();
    repeat (7) tick();
    chk("ldst_ld_t6", S_READ | S_MDR_IN, 1'b1);
    tick();
    IR_Data = ir_of(5'b00010);
    tick();
    chk("ldst_st_t0", V_T0, 1'b1);
    repeat (7) tick();
    chk("ldst_st_t7", S_WRITE, 1'b1);

    // Stop pulse that ends before the last execute edge is ignored.
    IR_Data = ir_of(5'b00011);
    do_reset();
    repeat (4) tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    repeat (2) tick();
    chk("stop_early_ignored", V_T0, 1'b1);

    // Stop during nop T3 parks the sequencer in HALT.
    IR_Data = ir_of(5'b11010);
    do_reset();
    repeat (4) tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("stop_halt_%0d", k), 33'd0, 1'b0);
      tick();
    end

    // halt opcode gives the same parked state.
    IR_Data = ir_of(5'b11011);
    do_reset();
    repeat (5) tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("op_halt_%0d", k), 33'd0, 1'b0);
      tick();
    end

    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL rw_exclusive: got %0d violating cycles, want 0", viol);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
